multi_timer_core: RTL and testbench

Parametrised multi-channel kitchen-timer core. Holds NUM_CH independent mm:ss BCD timers, each with its own preset, count, direction and alarm, driven by a shared 1 Hz tick enable. It sits between the button debouncers / clock divider and the 7-segment / VGA display path. It generalises the single-channel timer FSM with per-channel state, up/down targets and a selectable display channel.

---
 rtl/timer_pkg.sv | 32 +++
 rtl/bcd_time_counter.sv | 74 +++++++
 rtl/multi_timer_core.sv | 178 +++++++++++++++++
 tb/tb_multi_timer_core.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel mm:ss BCD timer core.
package timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DONE  = 3'd3
    } state_t;

    typedef struct packed {
        logic [3:0] min_1;
        logic [3:0] min_0;
        logic [3:0] sec_1;
        logic [3:0] sec_0;
    } bcd_time_t;

    localparam int MAX_SEC = 59;

    function automatic logic [7:0] bin_to_bcd6(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] ones;
        tens = v / 6'd10;
        ones = v - tens * 6'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    function automatic logic [5:0] clamp6(input logic [5:0] v, input logic [5:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Per-channel mm:ss BCD up/down counter, saturating at 00:00 and MAX_MIN:59.
// is_zero / at_target describe the value the next step would produce.
module bcd_time_counter
    import timer_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      load,
    input  bcd_time_t load_val,
    input  logic      en,
    input  logic      dir,
    input  bcd_time_t target,
    output bcd_time_t count,
    output logic      is_zero,
    output logic      at_target
);

    localparam logic [7:0] MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    bcd_time_t stepped;
    logic      at_max;
    logic      now_zero;

    assign at_max   = ({count.min_1, count.min_0} == MAX_MIN_BCD) &&
                      (count.sec_1 == 4'd5) && (count.sec_0 == 4'd9);
    assign now_zero = (count == '0);

    always_comb begin
        stepped = count;
        if (dir) begin
            if (!at_max) begin
                if (count.sec_0 != 4'd9) stepped.sec_0 = count.sec_0 + 4'd1;
                else begin
                    stepped.sec_0 = 4'd0;
                    if (count.sec_1 != 4'd5) stepped.sec_1 = count.sec_1 + 4'd1;
                    else begin
                        stepped.sec_1 = 4'd0;
                        if (count.min_0 != 4'd9) stepped.min_0 = count.min_0 + 4'd1;
                        else begin
                            stepped.min_0 = 4'd0;
                            stepped.min_1 = count.min_1 + 4'd1;
                        end
                    end
                end
            end
        end else if (!now_zero) begin
            if (count.sec_0 != 4'd0) stepped.sec_0 = count.sec_0 - 4'd1;
            else begin
                stepped.sec_0 = 4'd9;
                if (count.sec_1 != 4'd0) stepped.sec_1 = count.sec_1 - 4'd1;
                else begin
                    stepped.sec_1 = 4'd5;
                    if (count.min_0 != 4'd0) stepped.min_0 = count.min_0 - 4'd1;
                    else begin
                        stepped.min_0 = 4'd9;
                        stepped.min_1 = count.min_1 - 4'd1;
                    end
                end
            end
        end
    end

    assign is_zero   = (stepped == '0);
    assign at_target = (stepped == target);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     count <= '0;
        else if (load) count <= load_val;
        else if (en)   count <= stepped;
    end

endmodule

// File: rtl/multi_timer_core.sv
// NUM_CH independent mm:ss kitchen timers sharing one tick, with a selectable display channel.
// Optional TIMER_AUTO_RELOAD_EN: terminal count reloads and pulses alarm instead of latching DONE.
module multi_timer_core
    import timer_pkg::*;
#(
    parameter  int NUM_CH  = 4,
    parameter  int MAX_MIN = 59,
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [CW-1:0]     ch_sel,
    input  logic [5:0]        num,
    input  logic              up,
    input  logic              get_min,
    input  logic              get_sec,
    input  logic              start,
    input  logic              pause,
    input  logic              clear,
    output logic [15:0]       disp_bcd,
    output logic [2:0]        disp_state,
    output logic [NUM_CH-1:0] alarm,
    output logic              any_alarm
);

    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    assign min_bcd = bin_to_bcd6(clamp6(num, 6'(MAX_MIN)));
    assign sec_bcd = bin_to_bcd6(clamp6(num, 6'(MAX_SEC)));

    bcd_time_t ch_count [NUM_CH];
    state_t    ch_state [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t    state_q, state_d;
        bcd_time_t preset_q, preset_d, load_val, cnt;
        logic      dir_q, dir_d, load, en, hit, is_zero, at_target;
        logic      sel, c_clr, c_pau, c_sta, c_min, c_sec, tick_run, alarm_ch;
`ifdef TIMER_AUTO_RELOAD_EN
        logic      reload, pulse_q;
`endif

        // Only the highest-priority command addressed to this channel acts.
        assign sel      = (ch_sel == CW'(i));
        assign c_clr    = sel & clear;
        assign c_pau    = sel & pause & ~clear;
        assign c_sta    = sel & start & ~pause & ~clear;
        assign c_min    = sel & get_min & ~start & ~pause & ~clear;
        assign c_sec    = sel & get_sec & ~get_min & ~start & ~pause & ~clear;
        assign tick_run = tick & ~(sel & (start | pause));
        assign hit      = dir_q ? at_target : is_zero;

        bcd_time_counter #(.MAX_MIN(MAX_MIN)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .load      (load),
            .load_val  (load_val),
            .en        (en),
            .dir       (dir_q),
            .target    (preset_q),
            .count     (cnt),
            .is_zero   (is_zero),
            .at_target (at_target)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q  <= ST_IDLE;
                preset_q <= '0;
                dir_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                preset_q <= preset_d;
                dir_q    <= dir_d;
            end
        end

`ifdef TIMER_AUTO_RELOAD_EN
        always_ff @(posedge clk or posedge reset) begin
            if (reset) pulse_q <= 1'b0;
            else       pulse_q <= reload;
        end
`endif

        always_comb begin
            state_d  = state_q;
            preset_d = preset_q;
            dir_d    = dir_q;
            load     = 1'b0;
            load_val = preset_q;
            en       = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            reload   = 1'b0;
`endif
            if (c_min) {preset_d.min_1, preset_d.min_0} = min_bcd;
            if (c_sec) {preset_d.sec_1, preset_d.sec_0} = sec_bcd;
            if (c_clr) begin
                state_d  = ST_IDLE;
                preset_d = preset_q;
                load     = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (c_sta) begin
                            if (preset_q != '0) begin
                                state_d  = ST_RUN;
                                dir_d    = up;
                                load     = 1'b1;
                                load_val = up ? '0 : preset_q;
                            end
                        end else if (c_min | c_sec) begin
                            load     = 1'b1;
                            load_val = preset_d;
                        end
                    end
                    ST_PAUSE: if (c_sta) state_d = ST_RUN;
                    ST_RUN: begin
                        preset_d = preset_q;
                        if (c_pau) state_d = ST_PAUSE;
                        else if (tick_run) begin
                            en = 1'b1;
                            if (hit) begin
`ifdef TIMER_AUTO_RELOAD_EN
                                load     = 1'b1;
                                load_val = dir_q ? '0 : preset_q;
                                reload   = 1'b1;
`else
                                state_d  = ST_DONE;
`endif
                            end
                        end
                    end
                    default: preset_d = preset_q;
                endcase
            end
        end

        always_comb begin
`ifdef TIMER_AUTO_RELOAD_EN
            alarm_ch = pulse_q;
`else
            alarm_ch = (state_q == ST_DONE);
`endif
        end

        assign alarm[i]    = alarm_ch;
        assign ch_count[i] = cnt;
        assign ch_state[i] = state_q;
    end

    bcd_time_t sel_count;
    state_t    sel_state;

    always_comb begin
        sel_count = '0;
        sel_state = ST_IDLE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CW'(i)) begin
                sel_count = ch_count[i];
                sel_state = ch_state[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_bcd   <= 16'h0000;
            disp_state <= ST_IDLE;
            any_alarm  <= 1'b0;
        end else begin
            disp_bcd   <= sel_count;
            disp_state <= sel_state;
            any_alarm  <= |alarm;
        end
    end

endmodule

// File: tb/tb_multi_timer_core.sv
// Bench for multi_timer_core: integer-seconds reference model feeds a scoreboard queue.
module tb_multi_timer_core;

    localparam int NCH  = 4;
    localparam int MAXM = 59;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;
`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           tick = 1'b0, up = 1'b0;
    logic           get_min = 1'b0, get_sec = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [1:0]     ch_sel = '0;
    logic [5:0]     num = '0;
    logic [15:0]    disp_bcd;
    logic [2:0]     disp_state;
    logic [NCH-1:0] alarm;
    logic           any_alarm;

    always #5 clk = ~clk;

    multi_timer_core #(.NUM_CH(NCH), .MAX_MIN(MAXM)) dut (
        .clk(clk), .reset(reset), .tick(tick), .ch_sel(ch_sel), .num(num), .up(up),
        .get_min(get_min), .get_sec(get_sec), .start(start), .pause(pause), .clear(clear),
        .disp_bcd(disp_bcd), .disp_state(disp_state), .alarm(alarm), .any_alarm(any_alarm)
    );

    typedef struct {
        logic [15:0]    disp;
        logic [2:0]     st;
        logic [NCH-1:0] al;
        logic           any;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0, n_pass = 0;

    // Reference model: times kept as total seconds.
    int pmin[NCH], psec[NCH], cnt[NCH], st[NCH];
    bit dirv[NCH], pulse[NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [15:0] bcd(input int t);
        int m = t / 60, s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [NCH-1:0] m_alarm();
        logic [NCH-1:0] a;
        for (int c = 0; c < NCH; c++) a[c] = AUTO ? pulse[c] : (st[c] == DONE);
        return a;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            pmin[c] = 0; psec[c] = 0; cnt[c] = 0; st[c] = IDLE; dirv[c] = 0; pulse[c] = 0;
        end
    endtask

    task automatic model_step();
        exp_t e;
        e.disp = bcd(cnt[ch_sel]);
        e.st   = 3'(st[ch_sel]);
        e.any  = |m_alarm();
        for (int c = 0; c < NCH; c++) begin
            bit sel = (int'(ch_sel) == c);
            int pt  = pmin[c] * 60 + psec[c];
            int term;
            pulse[c] = 0;
            if (sel && clear) begin
                st[c] = IDLE; cnt[c] = pt;
            end else if (sel && pause) begin
                if (st[c] == RUN) st[c] = PAUSE;
            end else if (sel && start) begin
                if (st[c] == IDLE && pt != 0) begin
                    st[c] = RUN; dirv[c] = up; cnt[c] = up ? 0 : pt;
                end else if (st[c] == PAUSE) st[c] = RUN;
            end else begin
                if (sel && (get_min || get_sec) && (st[c] == IDLE || st[c] == PAUSE)) begin
                    if (get_min) pmin[c] = (int'(num) > MAXM) ? MAXM : int'(num);
                    else         psec[c] = (int'(num) > 59) ? 59 : int'(num);
                    if (st[c] == IDLE) cnt[c] = pmin[c] * 60 + psec[c];
                end
                if (tick && st[c] == RUN) begin
                    if (dirv[c]) cnt[c] = (cnt[c] < MAXM * 60 + 59) ? cnt[c] + 1 : cnt[c];
                    else         cnt[c] = (cnt[c] > 0) ? cnt[c] - 1 : 0;
                    term = dirv[c] ? pt : 0;
                    if (cnt[c] == term) begin
                        if (AUTO) begin
                            cnt[c] = dirv[c] ? 0 : pt; pulse[c] = 1;
                        end else st[c] = DONE;
                    end
                end
            end
        end
        e.al = m_alarm();
        q.push_back(e);
    endtask

    // One clock: predict, let the edge happen, then drop the single-cycle pulses.
    task automatic cyc();
        model_step();
        @(negedge clk); #1;
        tick = 0; get_min = 0; get_sec = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_disp_bcd", disp_bcd, 16'h0000);
        check("rst_disp_state", disp_state, IDLE);
        check("rst_alarm", alarm, '0);
        check("rst_any_alarm", any_alarm, 1'b0);
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic load(input int ch, input int m, input int s);
        ch_sel = 2'(ch); get_min = 1; num = 6'(m); cyc();
        ch_sel = 2'(ch); get_sec = 1; num = 6'(s); cyc();
    endtask

    task automatic go(input int ch, input bit u);
        ch_sel = 2'(ch); start = 1; up = u; cyc();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin tick = 1; cyc(); cyc(); end
    endtask

    always begin
        exp_t e;
        @(posedge clk); #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("disp_bcd", disp_bcd, e.disp);
            check("disp_state", disp_state, e.st);
            check("alarm", alarm, e.al);
            check("any_alarm", any_alarm, e.any);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        @(negedge clk); #1;
        do_reset();

        // Down count 01:05 to 00:00 on channel 0.
        load(0, 1, 5); go(0, 0); ticks(65);
        check("t1_disp_zero", disp_bcd, 16'h0000);
`ifndef TIMER_AUTO_RELOAD_EN
        check("t1_alarm0", alarm[0], 1'b1);
        check("t1_state_done", disp_state, DONE);
`endif
        ch_sel = 0; clear = 1; cyc();

        // Up count to preset 00:03 on channel 2.
        load(2, 0, 3); go(2, 1); ticks(3);
`ifndef TIMER_AUTO_RELOAD_EN
        check("t2_disp_003", disp_bcd, 16'h0003);
`endif
        ch_sel = 2; clear = 1; cyc();

        // Presets saturate, minute borrow.
        load(1, 63, 63); cyc();
        check("t3_sat_5959", disp_bcd, 16'h5959);
        load(1, 10, 0); go(1, 0); ticks(1);
        check("t3_borrow_0959", disp_bcd, 16'h0959);
        ch_sel = 1; clear = 1; cyc();

        // Pause on a tick cycle, resume, clear.
        load(3, 0, 10); go(3, 0);
        ch_sel = 3; tick = 1; pause = 1; cyc(); cyc();
        check("t4_pause_hold", disp_bcd, 16'h0010);
        check("t4_pause_state", disp_state, PAUSE);
        go(3, 0); ticks(2);
        check("t4_resume_0008", disp_bcd, 16'h0008);
        ch_sel = 3; clear = 1; cyc(); cyc();
        check("t4_clear_0010", disp_bcd, 16'h0010);
        check("t4_clear_idle", disp_state, IDLE);

        // Zero preset start, clear+start, reset mid-run.
        load(1, 0, 0); go(1, 0); cyc();
        check("t5_zero_start_idle", disp_state, IDLE);
        load(1, 0, 5); ch_sel = 1; clear = 1; start = 1; cyc(); cyc();
        check("t5_clr_start_idle", disp_state, IDLE);
        go(1, 0); ticks(1);
        do_reset();

        // Short auto-reload style run (latches DONE in the default build).
        load(0, 0, 2); go(0, 0); ticks(4);
        ch_sel = 0; clear = 1; cyc();

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            int r = $urandom_range(0, 31);
            ch_sel = 2'($urandom_range(0, NCH - 1));
            num    = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(0, 63));
            up     = 1'($urandom);
            tick   = 1'($urandom);
            case (r)
                0:       clear = 1;
                1:       pause = 1;
                2, 3:    start = 1;
                4, 5:    get_min = 1;
                6, 7, 8: get_sec = 1;
                9:       begin clear = 1; start = 1; end
                10:      begin get_min = 1; get_sec = 1; end
                default: ;
            endcase
            cyc();
        end
        cyc();
        check("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
